// File: rtl/proc_run_ctrl.sv
// Run controller for a single-cycle processor: resets it to a start PC, lets it run until
// the PC crosses an end threshold or a watchdog expires, then scores the data-memory output.
module proc_run_ctrl #(
    parameter int RST_CYCLES = 1,
    parameter int WDOG_MAX   = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        cont,
    input  logic [63:0] start_pc,
    input  logic [63:0] end_pc,
    input  logic [63:0] expected,
    input  logic [63:0] currentpc,
    input  logic [63:0] dmemout,
    output logic        proc_resetl,
    output logic [63:0] proc_startpc,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [7:0]  run_count,
    output logic [7:0]  pass_count,
    output logic        all_passed,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_SETTLE} state_t;

    localparam logic [15:0] WDOG_LAST = 16'(WDOG_MAX - 1);
    localparam logic [3:0]  RST_LAST  = 4'(RST_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  rst_cnt;
    logic [63:0] end_q;
    logic [63:0] exp_q;
    logic        released;
    logic        end_hit;
    logic        wdog_hit;
    logic        rst_last;
    logic        match;

    assign end_hit  = (currentpc >= end_q);
    assign wdog_hit = (cycle_count == WDOG_LAST);
    assign rst_last = (rst_cnt == RST_LAST);
    assign match    = (dmemout == exp_q);

    // The processor stays in reset from controller reset until the first RST phase finishes,
    // and afterwards free-runs except while in RST.
    assign proc_resetl = released && (state != S_RST);
    assign busy        = (state != S_IDLE);
    assign all_passed  = (run_count != 8'd0) && (pass_count == run_count);
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = cont ? S_RUN : S_RST;
            S_RST:    if (rst_last) state_nxt = S_RUN;
            S_RUN: begin
                // End condition wins over the watchdog when both fire together.
                if (end_hit)       state_nxt = S_SETTLE;
                else if (wdog_hit) state_nxt = S_IDLE;
            end
            S_SETTLE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_IDLE;
            rst_cnt      <= 4'd0;
            end_q        <= 64'd0;
            exp_q        <= 64'd0;
            released     <= 1'b0;
            proc_startpc <= 64'd0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= 16'd0;
            run_count    <= 8'd0;
            pass_count   <= 8'd0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        end_q       <= end_pc;
                        exp_q       <= expected;
                        cycle_count <= 16'd0;
                        timeout     <= 1'b0;
                        pass        <= 1'b0;
                        rst_cnt     <= 4'd0;
                        if (!cont) proc_startpc <= start_pc;
                    end
                end
                S_RST: begin
                    rst_cnt <= rst_cnt + 4'd1;
                    if (rst_last) released <= 1'b1;
                end
                S_RUN: begin
                    if (!end_hit) begin
                        if (wdog_hit) begin
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                            done    <= 1'b1;
                            if (run_count != 8'hFF) run_count <= run_count + 8'd1;
                        end else begin
                            cycle_count <= cycle_count + 16'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    pass <= match;
                    done <= 1'b1;
                    if (run_count != 8'hFF) run_count <= run_count + 8'd1;
                    if (match && pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
